// File: rtl/fsd_compute_sequencer_if.sv
// Handshake/bus bundle between the Floyd-Steinberg compute sequencer and its
// environment. It carries the start/busy/done control, the image-RAM read and
// write strobes, the datapath result handshake and the current pixel position.
// The master side is the sequencer. The slave side is the controller, RAM or
// datapath that surrounds it.
interface fsd_compute_sequencer_if #(
  parameter int IMAGEX = 4,
  parameter int IMAGEY = 3,
  parameter int ADDR_W = 4
);
  localparam int XW = $clog2(IMAGEX);
  localparam int YW = $clog2(IMAGEY);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              dp_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_sel;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;

  modport master (
    input  start, dp_valid,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_sel, cur_x, cur_y
  );

  modport slave (
    output start, dp_valid,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_sel, cur_x, cur_y
  );
endinterface

// File: rtl/fsd_compute_sequencer.sv
// Floyd-Steinberg compute sequencer.
// The sequencer walks the image one pixel at a time. For each pixel it does
// the following:
//   - issues one RAM read;
//   - waits for the datapath result handshake;
//   - writes the quantized pixel back;
//   - writes each in-bounds error-diffusion neighbour, in the fixed order
//     R (7/16), DL (3/16), D (5/16), DR (1/16).
// done pulses for one cycle after the last pixel retires.
// Optional build macro SERPENTINE_SCAN_EN: odd rows are walked right-to-left,
// and the horizontal neighbours mirror on those rows. When the macro is not
// defined, the walk is plain raster order.
module fsd_compute_sequencer #(
  parameter int IMAGEX = 4,
  parameter int IMAGEY = 3,
  parameter int ADDR_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  fsd_compute_sequencer_if.master       bus
);

`ifdef SERPENTINE_SCAN_EN
  localparam bit SERPENTINE = 1'b1;
`else
  localparam bit SERPENTINE = 1'b0;
`endif

  localparam int XW = $clog2(IMAGEX);
  localparam int YW = $clog2(IMAGEY);

  localparam logic [XW-1:0]     X_LAST = XW'(IMAGEX - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMAGEY - 1);
  localparam logic [ADDR_W-1:0] ROW    = ADDR_W'(IMAGEX);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WB_SELF,
    S_WB_R,
    S_WB_DL,
    S_WB_D,
    S_WB_DR,
    S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    SEL_SELF = 3'd0,
    SEL_R    = 3'd1,
    SEL_DL   = 3'd2,
    SEL_D    = 3'd3,
    SEL_DR   = 3'd4
  } sel_e;

  state_e state;

  // rd_addr is only updated when a pixel's read is issued. It therefore holds
  // the current pixel address for the whole write-back sequence.
  logic              reverse;
  logic              at_fwd_end;
  logic              at_back_end;
  logic              last_row;
  logic              last_pixel;
  logic              r_ok, dl_ok, d_ok, dr_ok;
  logic [ADDR_W-1:0] r_addr, dl_addr, d_addr, dr_addr;
  logic [XW-1:0]     nxt_x;
  logic [YW-1:0]     nxt_y;
  logic [ADDR_W-1:0] nxt_addr;
  state_e            after_self, after_r, after_dl, after_d;
  state_e            follow;
  logic [ADDR_W-1:0] follow_addr;
  sel_e              follow_sel;

  // Work out the scan geometry of the current pixel:
  //   - the scan direction;
  //   - which neighbours are in bounds, and their addresses;
  //   - the position of the next pixel.
  always_comb begin
    // NOTE: every signal gets a value on every path through this block;
    // a path that leaves a signal unassigned infers a latch.
    reverse     = SERPENTINE && bus.cur_y[0];
    at_fwd_end  = reverse ? (bus.cur_x == '0) : (bus.cur_x == X_LAST);
    at_back_end = reverse ? (bus.cur_x == X_LAST) : (bus.cur_x == '0);
    last_row    = (bus.cur_y == Y_LAST);
    last_pixel  = last_row && at_fwd_end;

    // "Forward" is the scan direction. The R and DR neighbours lie ahead of
    // the pixel; DL lies behind it.
    r_ok  = !at_fwd_end;
    dl_ok = !at_back_end && !last_row;
    d_ok  = !last_row;
    dr_ok = !at_fwd_end && !last_row;

    r_addr  = reverse ? bus.rd_addr - ONE       : bus.rd_addr + ONE;
    dl_addr = reverse ? bus.rd_addr + ROW + ONE : bus.rd_addr + ROW - ONE;
    d_addr  = bus.rd_addr + ROW;
    dr_addr = reverse ? bus.rd_addr + ROW - ONE : bus.rd_addr + ROW + ONE;

    if (at_fwd_end) begin
      // Row advance. A serpentine walk stays in the same column, because the
      // next row runs the other way.
      nxt_y    = bus.cur_y + YW'(1);
      nxt_x    = SERPENTINE ? bus.cur_x : '0;
      nxt_addr = SERPENTINE ? bus.rd_addr + ROW : bus.rd_addr + ONE;
    end else begin
      nxt_y    = bus.cur_y;
      nxt_x    = reverse ? bus.cur_x - XW'(1) : bus.cur_x + XW'(1);
      nxt_addr = reverse ? bus.rd_addr - ONE : bus.rd_addr + ONE;
    end
  end

  // Pick the next applicable write state. Out-of-bounds targets are skipped
  // with no bubble. S_IDLE stands for "no writes left for this pixel".
  always_comb begin
    after_d    = dr_ok ? S_WB_DR : S_IDLE;
    after_dl   = d_ok  ? S_WB_D  : after_d;
    after_r    = dl_ok ? S_WB_DL : after_dl;
    after_self = r_ok  ? S_WB_R  : after_r;

    follow = S_IDLE;
    case (state)
      S_WB_SELF: follow = after_self;
      S_WB_R:    follow = after_r;
      S_WB_DL:   follow = after_dl;
      S_WB_D:    follow = after_d;
      default:   follow = S_IDLE;
    endcase

    follow_addr = d_addr;
    follow_sel  = SEL_D;
    case (follow)
      S_WB_R:  begin follow_addr = r_addr;  follow_sel = SEL_R;  end
      S_WB_DL: begin follow_addr = dl_addr; follow_sel = SEL_DL; end
      S_WB_DR: begin follow_addr = dr_addr; follow_sel = SEL_DR; end
      default: begin follow_addr = d_addr;  follow_sel = SEL_D;  end
    endcase
  end

  // Sequencer FSM. Every output is registered and takes its value on entry
  // to the state that owns it.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every branch
    // below sees the pre-edge values, whatever order the statements are in.
    if (rst) begin
      state       <= S_IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_sel  <= SEL_SELF;
      bus.cur_x   <= '0;
      bus.cur_y   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_READ;
            bus.busy    <= 1'b1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
            bus.cur_x   <= '0;
            bus.cur_y   <= '0;
          end
        end

        S_READ: begin
          bus.rd_en <= 1'b0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.dp_valid) begin
            state       <= S_WB_SELF;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= bus.rd_addr;
            bus.wr_sel  <= SEL_SELF;
          end
        end

        S_WB_SELF, S_WB_R, S_WB_DL, S_WB_D, S_WB_DR: begin
          if (follow != S_IDLE) begin
            state       <= follow;
            bus.wr_addr <= follow_addr;
            bus.wr_sel  <= follow_sel;
          end else begin
            bus.wr_en <= 1'b0;
            if (last_pixel) begin
              state    <= S_FINISH;
              bus.done <= 1'b1;
            end else begin
              state       <= S_READ;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= nxt_addr;
              bus.cur_x   <= nxt_x;
              bus.cur_y   <= nxt_y;
            end
          end
        end

        S_FINISH: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsd_compute_sequencer.sv
// Scoreboard bench for fsd_compute_sequencer.
// A coordinate-level model expands each pass into its expected sequence of
// reads, writes and the done pulse, and queues them. A monitor on the falling
// edge pops one entry per strobe and compares it with the DUT. Build with
// SERPENTINE_SCAN_EN to exercise the serpentine walk.
module tb_fsd_compute_sequencer;
  localparam int IMAGEX = 4;
  localparam int IMAGEY = 3;
  localparam int ADDR_W = 4;
  localparam int TOTAL_WRITES = IMAGEX * IMAGEY + (IMAGEX - 1) * IMAGEY +
                                IMAGEX * (IMAGEY - 1) + 2 * (IMAGEX - 1) * (IMAGEY - 1);
`ifdef SERPENTINE_SCAN_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int kind;
    int addr;
    int sel;
    int x;
    int y;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   mode = 0;
  int   dones = 0;
  exp_t sb[$];

  fsd_compute_sequencer_if #(.IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .ADDR_W(ADDR_W)) bus ();

  fsd_compute_sequencer #(.IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    total++;
    bad++;
    $display("FAIL %s: info=%0d at %0t", name, info, $time);
  endtask

  // Reference model: the spec's neighbour rules applied to plain coordinates.
  task automatic push_target(input int nx, input int ny, input int sel);
    exp_t e;
    if (nx >= 0 && nx < IMAGEX && ny < IMAGEY) begin
      e.kind = K_WRITE; e.addr = ny * IMAGEX + nx; e.sel = sel; e.x = nx; e.y = ny;
      sb.push_back(e);
    end
  endtask

  task automatic push_pass();
    exp_t e;
    for (int yy = 0; yy < IMAGEY; yy++) begin
      int dir;
      dir = (SERP && (yy % 2 == 1)) ? -1 : 1;
      for (int k = 0; k < IMAGEX; k++) begin
        int xx;
        xx = (dir == 1) ? k : IMAGEX - 1 - k;
        e.kind = K_READ; e.addr = yy * IMAGEX + xx; e.sel = 0; e.x = xx; e.y = yy;
        sb.push_back(e);
        push_target(xx, yy, 0);
        push_target(xx + dir, yy, 1);
        push_target(xx - dir, yy + 1, 2);
        push_target(xx, yy + 1, 3);
        push_target(xx + dir, yy + 1, 4);
      end
    end
    e.kind = K_DONE; e.addr = 0; e.sel = 0; e.x = 0; e.y = 0;
    sb.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(bus.busy),    0);
    check({tag, "_done"},    32'(bus.done),    0);
    check({tag, "_rd_en"},   32'(bus.rd_en),   0);
    check({tag, "_wr_en"},   32'(bus.wr_en),   0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check({tag, "_wr_sel"},  32'(bus.wr_sel),  0);
    check({tag, "_cur_x"},   32'(bus.cur_x),   0);
    check({tag, "_cur_y"},   32'(bus.cur_y),   0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_passes(input int target);
    int n;
    n = 0;
    while ((dones < target || sb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("pass_timeout", sb.size());
  endtask

  // Datapath stand-in: 0 = always valid, 1 = random, 2 = held low for five
  // WAIT cycles after each read and then high (including during write-back).
  initial begin
    int since;
    since = 0;
    bus.dp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.rd_en) since = 0;
      else since++;
      case (mode)
        0:       bus.dp_valid = 1'b1;
        1:       bus.dp_valid = 1'($urandom_range(0, 1));
        default: bus.dp_valid = (since >= 6);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every strobe and checks WAIT-exit timing.
  initial begin
    exp_t e;
    bit   waiting;
    bit   after_done;
    bit   dpv_prev;
    int   edges;
    int   pass_writes;
    waiting = 0; after_done = 0; dpv_prev = 0; edges = 0; pass_writes = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        waiting = 0; after_done = 0; pass_writes = 0;
      end else begin
        if (after_done) begin
          check("busy_after_done", 32'(bus.busy), 0);
          after_done = 0;
        end
        if (bus.rd_en) begin
          if (sb.size() == 0) fail_now("unexpected_read", int'(bus.rd_addr));
          else begin
            e = sb.pop_front();
            check("rd_addr", 32'(bus.rd_addr), e.kind == K_READ ? e.addr : -1);
            check("cur_x",   32'(bus.cur_x),   e.kind == K_READ ? e.x : -1);
            check("cur_y",   32'(bus.cur_y),   e.kind == K_READ ? e.y : -1);
          end
          waiting = 1;
          edges = 0;
        end else if (waiting) begin
          edges++;
          check("wait_exit", 32'(bus.wr_en), 32'(edges >= 2 && dpv_prev));
          if (bus.wr_en) waiting = 0;
        end
        if (bus.wr_en) begin
          pass_writes++;
          if (sb.size() == 0) fail_now("unexpected_write", int'(bus.wr_addr));
          else begin
            e = sb.pop_front();
            check("wr_addr", 32'(bus.wr_addr), e.kind == K_WRITE ? e.addr : -1);
            check("wr_sel",  32'(bus.wr_sel),  e.kind == K_WRITE ? e.sel : -1);
          end
        end
        if (bus.done) begin
          if (sb.size() == 0) fail_now("unexpected_done", dones);
          else begin
            e = sb.pop_front();
            check("done_seq", 32'(e.kind), K_DONE);
          end
          check("busy_at_done", 32'(bus.busy), 1);
          check("pass_writes", 32'(pass_writes), TOTAL_WRITES);
          pass_writes = 0;
          dones++;
          after_done = 1;
        end
      end
      dpv_prev = bus.dp_valid;
    end
  end

  initial begin
    int  base;
    int  n;
    bit  found;
    bus.start = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    rst = 1'b0;

    // Pass A: dp_valid tied high.
    mode = 0;
    base = dones;
    push_pass();
    pulse_start();
    wait_passes(base + 1);

    // Pass B: random dp_valid, start held high throughout. The held start is
    // ignored while busy and relaunches pass C straight after FINISH.
    mode = 1;
    base = dones;
    push_pass();
    push_pass();
    @(posedge clk); #1 bus.start = 1'b1;
    n = 0;
    found = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.done) found = 1;
    end
    if (!found) fail_now("pass_b_done_timeout", n);
    @(negedge clk);
    @(negedge clk);
    #1 bus.start = 1'b0;
    wait_passes(base + 2);

    // Pass D: dp_valid held low for five WAIT cycles, then high into write-back.
    mode = 2;
    base = dones;
    push_pass();
    pulse_start();
    wait_passes(base + 1);

    // Reset asserted during the D write of pixel 5, then a fresh pass.
    mode = 1;
    push_pass();
    pulse_start();
    n = 0;
    found = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.wr_en && bus.wr_addr == ADDR_W'(5 + IMAGEX) && bus.wr_sel == 3'd3) found = 1;
    end
    if (!found) fail_now("wb_d_pixel5_timeout", n);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_idle("midpass_rst");
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    base = dones;
    push_pass();
    pulse_start();
    wait_passes(base + 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fsd_compute_sequencer.md
Name: fsd_compute_sequencer

Overview:
- Sequences the Floyd-Steinberg error-diffusion datapath over the image RAM during the top-level compute phase.
- Walks pixels in raster order. For each pixel it issues one read, then waits for the datapath result handshake.
- It then issues one write cycle per in-bounds target: the quantized self pixel and the 7/16, 3/16, 5/16 and 1/16 neighbours.
- Pulses done when the last pixel retires, which the top-level controller consumes as its compute-complete input.

Parameters:
- IMAGEX, 4, image width in pixels (≥2).
- IMAGEY, 3, image height in pixels (≥2).
- ADDR_W, 4, RAM address width, ≥ clog2(IMAGEX*IMAGEY).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- start  in  1  begin a compute pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- rd_en  out  1  read strobe to image RAM.
- rd_addr  out  ADDR_W  read address, y*IMAGEX+x.
- dp_valid  in  1  datapath result ready for the current pixel.
- wr_en  out  1  write strobe to image RAM.
- wr_addr  out  ADDR_W  write target address.
- wr_sel  out  3  write kind: 0 self, 1 right 7/16, 2 down-left 3/16, 3 down 5/16, 4 down-right 1/16.
- cur_x  out  clog2(IMAGEX)  current pixel column.
- cur_y  out  clog2(IMAGEY)  current pixel row.

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_sel=0, cur_x=0, cur_y=0. State is IDLE.
- rst at any time, including mid-pass, returns to IDLE in one cycle. No write strobe is emitted in the cycle after rst.
- States: IDLE, READ, WAIT, WB_SELF, WB_R, WB_DL, WB_D, WB_DR, FINISH.
- IDLE -> READ when start=1. cur_x and cur_y clear to 0.
- READ:
  - rd_en=1 for exactly one cycle at the current pixel address.
  - Then WAIT.
- WAIT:
  - Hold until dp_valid=1.
  - dp_valid in any other state is ignored.
  - The next cycle is WB_SELF. Read-to-first-write latency is therefore ≥2 cycles.
- WB_SELF: wr_en=1, wr_addr=pixel address, wr_sel=0.
- The neighbour write states follow, one cycle each, in the fixed order R, DL, D, DR. Out-of-bounds states are skipped entirely, with no idle cycle inserted:
  - R: skipped if x=IMAGEX-1; otherwise addr+1.
  - DL: skipped if x=0 or y=IMAGEY-1; otherwise addr+IMAGEX-1.
  - D: skipped if y=IMAGEY-1; otherwise addr+IMAGEX.
  - DR: skipped if x=IMAGEX-1 or y=IMAGEY-1; otherwise addr+IMAGEX+1.
- After the last applicable write:
  - If the pixel is not the last one, advance and go to READ. x increments; at x=IMAGEX-1, x wraps to 0 and y increments.
  - If the pixel is (IMAGEX-1, IMAGEY-1), go to FINISH.
- FINISH: done=1 for one cycle, then IDLE. busy drops in the same cycle as the IDLE entry.
- start asserted while busy is ignored. start held high in IDLE immediately after FINISH launches a new pass.
- Address arithmetic is unsigned ADDR_W. Bounds checks guarantee that no address is ≥ IMAGEX*IMAGEY.
- Write counts: corner (0,0) gives 4 writes; interior pixel 5; last column non-last row 3; last row 2 (self, R), except the last pixel, which gives 1.

Optional Feature:
- Macro SERPENTINE_SCAN_EN.
- When defined:
  - Odd rows (y[0]=1) are traversed right-to-left: x starts at IMAGEX-1 and decrements, with the row advance at x=0.
  - The horizontal neighbours mirror on those rows: "R" targets addr-1, skipped at x=0; "DL" targets addr+IMAGEX+1, skipped at x=IMAGEX-1; "DR" targets addr+IMAGEX-1, skipped at x=0.
  - wr_sel codes keep their weight meaning (1=7/16, 2=3/16, 4=1/16).
  - The final pixel is (0, IMAGEY-1) if IMAGEY is even, else (IMAGEX-1, IMAGEY-1).
- When undefined: pure raster order as above.

Test Plan:
- Reset then start=1 with IMAGEX=4, IMAGEY=3, dp_valid tied 1 -> first rd_addr=0; write sequence for pixel 0 is (0,sel0),(1,sel1),(4,sel3),(5,sel4); total writes = 41; exactly one done pulse; busy falls with done's trailing edge.
- Pixel (3,0), addr 3 -> writes (3,0),(6,2),(7,3) only; no R or DR write.
- Row y=2 -> each pixel writes self plus R only; pixel 11 writes only (11,0); then FINISH.
- dp_valid held 0 for 5 cycles in WAIT, with spurious dp_valid pulses during WB_* states -> no write until dp_valid in WAIT; no extra writes.
- rst asserted in WB_D of pixel 5 -> next cycle IDLE, all outputs 0; a new start restarts at rd_addr=0.
- With SERPENTINE_SCAN_EN, row 1 order is addr 7,6,5,4; pixel 7 writes (7,0),(6,1),(11,3),(10,4); final pixel is 11 and done pulses once.
